// File: rtl/y86_pipe_pkg.sv
// Shared Y86 pipeline constants: instruction/register codes, status codes
// and the W-stage payload bundle with its bubble value.
package y86_pipe_pkg;

  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] STAT_BUB = 3'd0;
  localparam logic [2:0] SAOK     = 3'd1;
  localparam logic [2:0] SADR     = 3'd2;
  localparam logic [2:0] SINS     = 3'd3;
  localparam logic [2:0] SHLT     = 3'd4;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } w_bundle_t;

  localparam int unsigned W_BUNDLE_W = $bits(w_bundle_t);

  localparam w_bundle_t W_BUBBLE = '{
    stat:  STAT_BUB,
    icode: INOP,
    val_e: 64'd0,
    val_m: 64'd0,
    dst_e: RNONE,
    dst_m: RNONE
  };

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Handshake, pipeline-control and statistics signals of pipe_stage_buf.
interface pipe_stage_buf_if
  import y86_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = W_BUNDLE_W,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic              stall_i;
  logic              bubble_i;
  logic              in_valid_i;
  logic [DATA_W-1:0] in_data_i;
  logic              in_ready_o;
  logic              out_valid_o;
  logic [DATA_W-1:0] out_data_o;
  logic              out_ready_i;
  logic [OCC_W-1:0]  occupancy_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  modport master (
    output stall_i, bubble_i, in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, occupancy_o,
           stall_cnt_o, bubble_cnt_o
  );

  modport slave (
    input  stall_i, bubble_i, in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, occupancy_o,
           stall_cnt_o, bubble_cnt_o
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Small circular FIFO between pipeline stages with stall (freeze) and
// bubble (flush) control; shows the bubble payload whenever it is empty.
module pipe_stage_buf
  import y86_pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = W_BUNDLE_W,
  parameter int unsigned       DEPTH      = 2,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(W_BUBBLE),
  parameter int unsigned       CNT_W      = 16
) (
  input logic             clk_i,
  input logic             rst_i,
  pipe_stage_buf_if.slave bus
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [OCC_W-1:0]  occ, occ_nxt;
  logic              full, not_empty, push, pop;

  assign full      = (occ == OCC_W'(DEPTH));
  assign not_empty = (occ != '0);

  // Ready never looks at out_ready_i: a slot freed by a pop is reusable next cycle.
  assign bus.in_ready_o = !full && !bus.stall_i && !bus.bubble_i;
  assign push = bus.in_valid_i && bus.in_ready_o;
  assign pop  = not_empty && bus.out_ready_i && !bus.stall_i && !bus.bubble_i;

  always_comb begin
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    occ_nxt    = occ;
    if (pop) begin
      rd_ptr_nxt = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
    end
    if (push) begin
      wr_ptr_nxt = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_nxt = occ + OCC_W'(1);
      2'b01:   occ_nxt = occ - OCC_W'(1);
      default: occ_nxt = occ;
    endcase
  end

  // Reset beats bubble; bubble beats stall; stall gates push/pop already.
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.bubble_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      occ    <= occ_nxt;
    end
  end

  // Storage is not reset; stale entries are never visible once occ is cleared.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data_i;
    end
  end

  assign bus.out_valid_o = not_empty;
  assign bus.out_data_o  = not_empty ? mem[rd_ptr] : BUBBLE_VAL;
  assign bus.occupancy_o = occ;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (bus.stall_i && !bus.bubble_i),
    .cnt_o (bus.stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (bus.bubble_i && not_empty),
    .cnt_o (bus.bubble_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf (DATA_W=8, DEPTH=2, BUBBLE_VAL=F0, CNT_W=4):
// directed vector table, stall saturation sequence, then random traffic vs a queue model.
module tb_pipe_stage_buf;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEP   = 2;
  localparam int unsigned CW    = 4;
  localparam logic [7:0]  BUB   = 8'hF0;
  localparam int          CMAX  = 15;

  logic clk;
  logic rst;

  pipe_stage_buf_if #(.DATA_W(DW), .DEPTH(DEP), .CNT_W(CW)) bus ();

  pipe_stage_buf #(
    .DATA_W(DW), .DEPTH(DEP), .BUBBLE_VAL(BUB), .CNT_W(CW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural reference: a queue of bytes plus two saturating counts.
  logic [7:0] mq[$];
  int         m_scnt = 0;
  int         m_bcnt = 0;
  bit         m_known = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle: compare pre-edge outputs to the model, advance model, clock.
  task automatic apply(input bit r, input bit st, input bit bb, input bit iv,
                       input logic [7:0] d, input bit ordy);
    bit exp_rdy;
    rst            = r;
    bus.stall_i    = st;
    bus.bubble_i   = bb;
    bus.in_valid_i = iv;
    bus.in_data_i  = d;
    bus.out_ready_i = ordy;
    #1;
    exp_rdy = (mq.size() < DEP) && !st && !bb;
    if (m_known) begin
      chk("m_in_ready",  32'(bus.in_ready_o),  32'(exp_rdy));
      chk("m_out_valid", 32'(bus.out_valid_o), 32'(mq.size() != 0));
      chk("m_out_data",  32'(bus.out_data_o),  32'((mq.size() != 0) ? mq[0] : BUB));
      chk("m_occ",       32'(bus.occupancy_o), 32'(mq.size()));
      chk("m_stall_cnt", 32'(bus.stall_cnt_o), 32'(m_scnt));
      chk("m_bubble_cnt",32'(bus.bubble_cnt_o),32'(m_bcnt));
    end
    if (r) begin
      mq.delete(); m_scnt = 0; m_bcnt = 0; m_known = 1'b1;
    end else if (bb) begin
      if (mq.size() != 0 && m_bcnt < CMAX) m_bcnt++;
      mq.delete();
    end else if (st) begin
      if (m_scnt < CMAX) m_scnt++;
    end else begin
      if (mq.size() != 0 && ordy) void'(mq.pop_front());
      if (exp_rdy && iv) mq.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         r, st, bb, iv;
    logic [7:0] d;
    bit         ordy;
    int         e_occ;
    logic [7:0] e_data;
    int         e_s, e_b;
  } vec_t;

  vec_t tbl[22];

  initial begin
    // Expected values are the post-edge state after each row is applied.
    tbl[0]  = '{1,0,0,0,8'h00,0, 0,8'hF0,0,0};
    tbl[1]  = '{0,0,0,0,8'h00,0, 0,8'hF0,0,0};
    tbl[2]  = '{0,0,0,1,8'h11,0, 1,8'h11,0,0};
    tbl[3]  = '{0,0,0,1,8'h22,0, 2,8'h11,0,0};
    tbl[4]  = '{0,0,0,0,8'h00,1, 1,8'h22,0,0};
    tbl[5]  = '{0,0,0,0,8'h00,1, 0,8'hF0,0,0};
    tbl[6]  = '{0,0,0,1,8'h11,0, 1,8'h11,0,0};
    tbl[7]  = '{0,0,0,1,8'h22,0, 2,8'h11,0,0};
    tbl[8]  = '{0,0,0,1,8'h33,1, 1,8'h22,0,0};
    tbl[9]  = '{0,0,0,1,8'h44,1, 1,8'h44,0,0};
    tbl[10] = '{0,0,0,1,8'h55,1, 1,8'h55,0,0};
    tbl[11] = '{0,0,0,1,8'h66,1, 1,8'h66,0,0};
    tbl[12] = '{0,0,0,1,8'h77,1, 1,8'h77,0,0};
    tbl[13] = '{0,0,0,1,8'h88,1, 1,8'h88,0,0};
    tbl[14] = '{0,0,0,1,8'h99,1, 1,8'h99,0,0};
    tbl[15] = '{0,1,0,1,8'hAA,1, 1,8'h99,1,0};
    tbl[16] = '{0,1,0,1,8'hAB,1, 1,8'h99,2,0};
    tbl[17] = '{0,1,0,1,8'hAC,1, 1,8'h99,3,0};
    tbl[18] = '{0,1,1,1,8'hAD,1, 0,8'hF0,3,1};
    tbl[19] = '{0,0,0,1,8'h11,0, 1,8'h11,3,1};
    tbl[20] = '{0,0,0,1,8'h22,0, 2,8'h11,3,1};
    tbl[21] = '{1,0,1,1,8'h33,1, 0,8'hF0,0,0};

    rst = 1'b0;
    bus.stall_i = 1'b0; bus.bubble_i = 1'b0; bus.in_valid_i = 1'b0;
    bus.in_data_i = '0; bus.out_ready_i = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      apply(tbl[i].r, tbl[i].st, tbl[i].bb, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      chk($sformatf("t%0d_occ", i),    32'(bus.occupancy_o),  32'(tbl[i].e_occ));
      chk($sformatf("t%0d_valid", i),  32'(bus.out_valid_o),  32'(tbl[i].e_occ != 0));
      chk($sformatf("t%0d_data", i),   32'(bus.out_data_o),   32'(tbl[i].e_data));
      chk($sformatf("t%0d_scnt", i),   32'(bus.stall_cnt_o),  32'(tbl[i].e_s));
      chk($sformatf("t%0d_bcnt", i),   32'(bus.bubble_cnt_o), 32'(tbl[i].e_b));
    end

    // Idle after reset: buffer ready again.
    bus.stall_i = 1'b0; bus.bubble_i = 1'b0; rst = 1'b0; #1;
    chk("post_rst_in_ready", 32'(bus.in_ready_o), 32'd1);

    // Bubble on an empty buffer does not count; long stall saturates.
    apply(0, 0, 1, 1, 8'h5A, 1);
    chk("empty_bubble_bcnt", 32'(bus.bubble_cnt_o), 32'd0);
    for (int i = 0; i < 20; i++) begin
      apply(0, 1, 0, 1, 8'h5A, 1);
      chk($sformatf("sat_s%0d", i), 32'(bus.stall_cnt_o), 32'((i + 1 > 15) ? 15 : i + 1));
    end
    chk("sat_occ", 32'(bus.occupancy_o), 32'd0);

    // Full buffer: in_ready must stay low even while popping.
    apply(1, 0, 0, 0, 8'h00, 0);
    apply(0, 0, 0, 1, 8'hC1, 0);
    apply(0, 0, 0, 1, 8'hC2, 0);
    bus.out_ready_i = 1'b1; bus.in_valid_i = 1'b1; #1;
    chk("full_pop_in_ready", 32'(bus.in_ready_o), 32'd0);

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 12),
            ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 70),
            8'($urandom), ($urandom_range(0, 99) < 60));
    end
    apply(0, 0, 0, 0, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter DATA_W, default 64+64+4+4+4+3=143; payload width (W-stage bundle: stat, icode, valE, valM, dstE, dstM).
REQ-002 Parameter DEPTH, default 2; entry count, legal range 1..4.
REQ-003 Parameter BUBBLE_VAL, default W-stage bubble constant (stat 0, icode INOP, valE/valM 0, dstE/dstM RNONE); payload shown when no valid entry is held.
REQ-004 Parameter CNT_W, default 16; width of statistics counters.
REQ-005 clk_i  input  1  single clock, all state updates on its rising edge.
REQ-006 rst_i  input  1  reset, synchronous, active-high.
REQ-007 stall_i  input  1  freeze: no push, no pop, state held.
REQ-008 bubble_i  input  1  flush: discard all entries; has priority over stall_i.
REQ-009 in_valid_i  input  1  upstream offers in_data_i.
REQ-010 in_data_i  input  DATA_W  upstream payload.
REQ-011 in_ready_o  output  1  buffer accepts a push this cycle.
REQ-012 out_valid_o  output  1  head entry valid.
REQ-013 out_data_o  output  DATA_W  head payload, or BUBBLE_VAL when empty.
REQ-014 out_ready_i  input  1  downstream consumes head.
REQ-015 occupancy_o  output  $clog2(DEPTH+1)  valid entries held.
REQ-016 stall_cnt_o  output  CNT_W  cycles with stall_i=1 and bubble_i=0.
REQ-017 bubble_cnt_o  output  CNT_W  cycles with bubble_i=1 that discarded at least one entry.

Function
REQ-018 Storage SHALL be a DEPTH-entry circular FIFO with read/write pointers wrapping modulo DEPTH.
REQ-019 in_ready_o SHALL equal (occupancy_o < DEPTH) and stall_i=0 and bubble_i=0; no combinational path from out_ready_i.
REQ-020 Push SHALL occur when in_valid_i and in_ready_o; payload written at write pointer on the clock edge.
REQ-021 Pop SHALL occur when out_valid_o, out_ready_i, stall_i=0, bubble_i=0.
REQ-022 Push-to-output latency SHALL be exactly 1 cycle when empty; no combinational in-to-out bypass.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged; legal at any occupancy including full (pop frees slot next cycle only; in_ready_o stays 0 while full).
REQ-024 out_valid_o SHALL equal (occupancy_o != 0); out_data_o SHALL be the head entry when valid, else BUBBLE_VAL.
REQ-025 bubble_i=1 SHALL zero occupancy and both pointers on the next edge regardless of stall_i, in_valid_i, out_ready_i; next-cycle out_data_o = BUBBLE_VAL.
REQ-026 stall_i=1 with bubble_i=0 SHALL hold pointers, occupancy and entries unchanged.
REQ-027 Counters SHALL increment by 1 per qualifying cycle and saturate at all-ones, never wrap.
REQ-028 Push when full or pop when empty SHALL be impossible by construction; no error state.

Reset
REQ-029 rst_i=1 SHALL, on the next edge, clear occupancy, pointers and both counters to 0; out_valid_o=0, out_data_o=BUBBLE_VAL, in_ready_o=1 (when stall_i=0, bubble_i=0) in the following cycle.
REQ-030 rst_i SHALL have priority over bubble_i and stall_i; entry storage contents need not be cleared.
REQ-031 Reset mid-operation SHALL drop all held entries; no pop is reported in the reset cycle.

Structure
REQ-032 INOP, RNONE, stat codes and the W-stage bubble constant SHALL live in the shared package y86_pipe_pkg; the defines header remains the source for existing stages.
REQ-033 One sub-module sat_counter (parameter CNT_W; inputs clk_i, rst_i, inc_i; output cnt_o) SHALL implement both statistics counters.
REQ-034 With DEPTH=1 the block SHALL behave as a stall/bubble pipeline register plus handshake.

Verification (DATA_W=8, DEPTH=2, BUBBLE_VAL=8'hF0, CNT_W=4)
REQ-035 Reset then idle -> out_valid_o=0, out_data_o=8'hF0, occupancy_o=0, in_ready_o=1.
REQ-036 Push 8'h11, 8'h22 with out_ready_i=0 -> occupancy 2, in_ready_o=0, out_data_o=8'h11; then out_ready_i=1 -> 8'h11, 8'h22 popped in order, then out_data_o=8'hF0.
REQ-037 Full (8'h11, 8'h22), push 8'h33 while popping -> 8'h33 rejected, occupancy 1, head 8'h22; continuous push/pop for 6 cycles -> pointers wrap, order preserved.
REQ-038 Occupancy 1, stall_i=1 for 3 cycles with in_valid_i=1, out_ready_i=1 -> state frozen, stall_cnt_o=3; stall_i=1 and bubble_i=1 together -> emptied, bubble_cnt_o=1, stall_cnt_o unchanged.
REQ-039 stall_i held 20 cycles -> stall_cnt_o saturates at 4'hF.
REQ-040 Occupancy 2 and rst_i=1 with bubble_i=1 -> next cycle occupancy 0, all counters 0, bubble_cnt_o=0.
